// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with two write ports,
// write-through bypass on every read port, an optional hardwired zero
// register and a per-register busy scoreboard for in-order issue.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset (clears storage and busy bits)
//   readaddr   : NUM_READ packed read addresses, port i at [i*AW +: AW]
//   readdata   : NUM_READ packed read data, port i at [i*WIDTH +: WIDTH]
//   readbusy   : per-read-port busy flag of the addressed register
//   we0/writeaddr0/writedata0 : write port 0
//   we1/writeaddr1/writedata1 : write port 1 (wins over port 0 on same address)
//   set_busy/set_addr         : mark a register as having a pending producer
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_READ = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_READ*AW-1:0]    readaddr,
    output logic [NUM_READ*WIDTH-1:0] readdata,
    output logic [NUM_READ-1:0]       readbusy,
    input  logic                      we0,
    input  logic [AW-1:0]             writeaddr0,
    input  logic [WIDTH-1:0]          writedata0,
    input  logic                      we1,
    input  logic [AW-1:0]             writeaddr1,
    input  logic [WIDTH-1:0]          writedata1,
    input  logic                      set_busy,
    input  logic [AW-1:0]             set_addr
);

    localparam logic ZERO_EN = (ZERO_REG != 0);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0] busy_r;

    logic we0_eff_s;
    logic we1_eff_s;
    logic set_eff_s;

    // Qualify requests: the zero register swallows writes and sets, and
    // port 0 loses a same-address conflict entirely (storage and bypass).
    always_comb begin
        we1_eff_s = we1 && !(ZERO_EN && (writeaddr1 == {AW{1'b0}}));
        we0_eff_s = we0 && !(ZERO_EN && (writeaddr0 == {AW{1'b0}}))
                        && !(we1 && (writeaddr1 == writeaddr0));
        set_eff_s = set_busy && !(ZERO_EN && (set_addr == {AW{1'b0}}));
    end

    // Register storage: cleared on reset, otherwise written by both ports.
    // A conflict never reaches here with both enables set on one address.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_r[k] <= {WIDTH{1'b0}};
            end
        end else begin
            if (we0_eff_s) begin
                mem_r[writeaddr0] <= writedata0;
            end
            if (we1_eff_s) begin
                mem_r[writeaddr1] <= writedata1;
            end
        end
    end

    // Busy scoreboard: a new producer (set) outranks a completing write
    // to the same register in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= {DEPTH{1'b0}};
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (set_eff_s && (set_addr == AW'(k))) begin
                    busy_r[k] <= 1'b1;
                end else if ((we0_eff_s && (writeaddr0 == AW'(k))) ||
                             (we1_eff_s && (writeaddr1 == AW'(k)))) begin
                    busy_r[k] <= 1'b0;
                end else begin
                    busy_r[k] <= busy_r[k];
                end
            end
        end
    end

    // Combinational read ports with write-through bypass; reset forces zero,
    // and readbusy drops on a bypass hit so it always agrees with readdata.
    always_comb begin
        logic [AW-1:0] ra;
        readdata = {(NUM_READ*WIDTH){1'b0}};
        readbusy = {NUM_READ{1'b0}};
        ra       = {AW{1'b0}};
        for (int i = 0; i < NUM_READ; i++) begin
            ra = readaddr[i*AW +: AW];
            if (rst) begin
                readdata[i*WIDTH +: WIDTH] = {WIDTH{1'b0}};
                readbusy[i]                = 1'b0;
            end else if (ZERO_EN && (ra == {AW{1'b0}})) begin
                readdata[i*WIDTH +: WIDTH] = {WIDTH{1'b0}};
                readbusy[i]                = 1'b0;
            end else if (we1_eff_s && (writeaddr1 == ra)) begin
                readdata[i*WIDTH +: WIDTH] = writedata1;
                readbusy[i]                = 1'b0;
            end else if (we0_eff_s && (writeaddr0 == ra)) begin
                readdata[i*WIDTH +: WIDTH] = writedata0;
                readbusy[i]                = 1'b0;
            end else begin
                readdata[i*WIDTH +: WIDTH] = mem_r[ra];
                readbusy[i]                = busy_r[ra];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: instance A uses the default geometry (32x32, two
// read ports, zero register on), instance B uses 64x16 with four read ports
// and the zero register off. A behavioural model of each tracks storage and
// busy bits; expected reads are derived from it and the current inputs.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [9:0]  a_raddr;
    logic [63:0] a_rdata;
    logic [1:0]  a_rbusy;
    logic        a_we0, a_we1, a_sb;
    logic [4:0]  a_wa0, a_wa1, a_sa;
    logic [31:0] a_wd0, a_wd1;

    logic [23:0] b_raddr;
    logic [63:0] b_rdata;
    logic [3:0]  b_rbusy;
    logic        b_we0, b_we1, b_sb;
    logic [5:0]  b_wa0, b_wa1, b_sa;
    logic [15:0] b_wd0, b_wd1;

    int checks = 0;
    int errors = 0;

    logic [31:0] ma_mem [32];
    logic        ma_busy [32];
    logic [15:0] mb_mem [64];
    logic        mb_busy [64];

    regfile_mp #(.WIDTH(32), .DEPTH(32), .NUM_READ(2), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst), .readaddr(a_raddr), .readdata(a_rdata), .readbusy(a_rbusy),
        .we0(a_we0), .writeaddr0(a_wa0), .writedata0(a_wd0),
        .we1(a_we1), .writeaddr1(a_wa1), .writedata1(a_wd1),
        .set_busy(a_sb), .set_addr(a_sa)
    );

    regfile_mp #(.WIDTH(16), .DEPTH(64), .NUM_READ(4), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .readaddr(b_raddr), .readdata(b_rdata), .readbusy(b_rbusy),
        .we0(b_we0), .writeaddr0(b_wa0), .writedata0(b_wd0),
        .we1(b_we1), .writeaddr1(b_wa1), .writedata1(b_wd1),
        .set_busy(b_sb), .set_addr(b_sa)
    );

    // Expected read value of A at address a given model state and current inputs.
    function automatic logic [31:0] ea_data(input logic [4:0] a);
        if (rst || a == 5'd0) return 32'd0;
        if (a_we1 && a_wa1 == a) return a_wd1;
        if (a_we0 && a_wa0 == a) return a_wd0;
        return ma_mem[a];
    endfunction

    function automatic logic ea_busy(input logic [4:0] a);
        if (rst || a == 5'd0) return 1'b0;
        if ((a_we1 && a_wa1 == a) || (a_we0 && a_wa0 == a)) return 1'b0;
        return ma_busy[a];
    endfunction

    function automatic logic [15:0] eb_data(input logic [5:0] a);
        if (rst) return 16'd0;
        if (b_we1 && b_wa1 == a) return b_wd1;
        if (b_we0 && b_wa0 == a) return b_wd0;
        return mb_mem[a];
    endfunction

    function automatic logic eb_busy(input logic [5:0] a);
        if (rst) return 1'b0;
        if ((b_we1 && b_wa1 == a) || (b_we0 && b_wa0 == a)) return 1'b0;
        return mb_busy[a];
    endfunction

    task automatic idle();
        a_we0 = 1'b0; a_we1 = 1'b0; a_sb = 1'b0;
        b_we0 = 1'b0; b_we1 = 1'b0; b_sb = 1'b0;
    endtask

    // Advance one clock and apply the same edge to the reference models.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 32; k++) begin ma_mem[k] = 32'd0; ma_busy[k] = 1'b0; end
            for (int k = 0; k < 64; k++) begin mb_mem[k] = 16'd0; mb_busy[k] = 1'b0; end
        end else begin
            if (a_we0 && a_wa0 != 5'd0 && !(a_we1 && a_wa1 == a_wa0)) begin ma_mem[a_wa0] = a_wd0; ma_busy[a_wa0] = 1'b0; end
            if (a_we1 && a_wa1 != 5'd0) begin ma_mem[a_wa1] = a_wd1; ma_busy[a_wa1] = 1'b0; end
            if (a_sb && a_sa != 5'd0) ma_busy[a_sa] = 1'b1;
            if (b_we0 && !(b_we1 && b_wa1 == b_wa0)) begin mb_mem[b_wa0] = b_wd0; mb_busy[b_wa0] = 1'b0; end
            if (b_we1) begin mb_mem[b_wa1] = b_wd1; mb_busy[b_wa1] = 1'b0; end
            if (b_sb) mb_busy[b_sa] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        a_we0 = 1'b1; a_wa0 = 5'd5; a_wd0 = 32'hDEADBEEF; a_raddr = {5'd5, 5'd5};
        b_we1 = 1'b1; b_wa1 = 6'd5; b_wd1 = 16'hBEEF;     b_raddr = {6'd5, 6'd5, 6'd5, 6'd5};
        #1;
        checks++; if (a_rdata !== 64'd0 || a_rbusy !== 2'b00) begin errors++; $display("FAIL reset_force_a: got %h/%b expected 0/00", a_rdata, a_rbusy); end
        checks++; if (b_rdata !== 64'd0 || b_rbusy !== 4'b0000) begin errors++; $display("FAIL reset_force_b: got %h/%b expected 0/0000", b_rdata, b_rbusy); end
        tick(); tick();
        rst = 1'b0; idle();
        for (int k = 0; k < 32; k++) begin
            a_raddr = {5'(k), 5'(k)}; #1;
            checks++; if (a_rdata !== 64'd0 || a_rbusy !== 2'b00) begin errors++; $display("FAIL reset_clear_a addr %0d: got %h/%b expected 0/00", k, a_rdata, a_rbusy); end
        end
        for (int k = 0; k < 64; k++) begin
            b_raddr = {6'(k), 6'(k), 6'(k), 6'(k)}; #1;
            checks++; if (b_rdata !== 64'd0 || b_rbusy !== 4'b0000) begin errors++; $display("FAIL reset_clear_b addr %0d: got %h/%b expected 0/0000", k, b_rdata, b_rbusy); end
        end
    endtask

    task automatic test_bypass();
        idle();
        a_we0 = 1'b1; a_wa0 = 5'd3; a_wd0 = 32'h12345678; a_raddr = {5'd1, 5'd3}; #1;
        checks++; if (a_rdata[31:0] !== 32'h12345678) begin errors++; $display("FAIL bypass_same_cycle: got %h expected 12345678", a_rdata[31:0]); end
        checks++; if (a_rdata[63:32] !== 32'd0) begin errors++; $display("FAIL bypass_other_port: got %h expected 0", a_rdata[63:32]); end
        tick();
        idle(); a_raddr = {5'd3, 5'd3}; #1;
        checks++; if (a_rdata !== {32'h12345678, 32'h12345678}) begin errors++; $display("FAIL bypass_stored: got %h expected 1234567812345678", a_rdata); end
    endtask

    task automatic test_conflict();
        idle();
        a_we0 = 1'b1; a_wa0 = 5'd7; a_wd0 = 32'hAAAA0000;
        a_we1 = 1'b1; a_wa1 = 5'd7; a_wd1 = 32'h5555FFFF; a_raddr = {5'd7, 5'd7}; #1;
        checks++; if (a_rdata !== {32'h5555FFFF, 32'h5555FFFF}) begin errors++; $display("FAIL conflict_bypass: got %h expected 5555FFFF x2", a_rdata); end
        tick();
        idle(); #1;
        checks++; if (a_rdata[31:0] !== 32'h5555FFFF) begin errors++; $display("FAIL conflict_stored: got %h expected 5555FFFF", a_rdata[31:0]); end
    endtask

    task automatic test_zero_reg();
        idle();
        a_we1 = 1'b1; a_wa1 = 5'd0; a_wd1 = 32'hFFFFFFFF; a_sb = 1'b1; a_sa = 5'd0; a_raddr = {5'd0, 5'd0}; #1;
        checks++; if (a_rdata !== 64'd0 || a_rbusy !== 2'b00) begin errors++; $display("FAIL zero_same_cycle: got %h/%b expected 0/00", a_rdata, a_rbusy); end
        tick();
        idle(); #1;
        checks++; if (a_rdata !== 64'd0 || a_rbusy !== 2'b00) begin errors++; $display("FAIL zero_after: got %h/%b expected 0/00", a_rdata, a_rbusy); end
        // Zero register disabled: address 0 is an ordinary register on B.
        b_we0 = 1'b1; b_wa0 = 6'd0; b_wd0 = 16'h1234; b_raddr = 24'd0; #1;
        checks++; if (b_rdata !== {4{16'h1234}}) begin errors++; $display("FAIL nozero_bypass: got %h expected 1234 x4", b_rdata); end
        tick();
        idle(); b_sb = 1'b1; b_sa = 6'd0; tick();
        idle(); #1;
        checks++; if (b_rdata !== {4{16'h1234}} || b_rbusy !== 4'b1111) begin errors++; $display("FAIL nozero_stored: got %h/%b expected 1234 x4/1111", b_rdata, b_rbusy); end
    endtask

    task automatic test_scoreboard();
        idle();
        a_sb = 1'b1; a_sa = 5'd9; a_raddr = {5'd9, 5'd9}; #1;
        checks++; if (a_rbusy !== 2'b00) begin errors++; $display("FAIL busy_not_yet: got %b expected 00", a_rbusy); end
        tick();
        idle(); #1;
        checks++; if (a_rbusy !== 2'b11) begin errors++; $display("FAIL busy_set: got %b expected 11", a_rbusy); end
        a_we0 = 1'b1; a_wa0 = 5'd9; a_wd0 = 32'h42; #1;
        checks++; if (a_rbusy !== 2'b00 || a_rdata[31:0] !== 32'h42) begin errors++; $display("FAIL busy_write_hit: got %b/%h expected 00/00000042", a_rbusy, a_rdata[31:0]); end
        tick();
        idle(); #1;
        checks++; if (a_rbusy !== 2'b00) begin errors++; $display("FAIL busy_cleared: got %b expected 00", a_rbusy); end
        a_sb = 1'b1; a_sa = 5'd9; a_we1 = 1'b1; a_wa1 = 5'd9; a_wd1 = 32'h77; tick();
        idle(); #1;
        checks++; if (a_rbusy !== 2'b11 || a_rdata[31:0] !== 32'h77) begin errors++; $display("FAIL busy_set_wins: got %b/%h expected 11/00000077", a_rbusy, a_rdata[31:0]); end
    endtask

    task automatic test_wide();
        idle();
        b_raddr = 24'd0; #1;
        checks++; if (b_rdata[31:16] !== 16'h1234) begin errors++; $display("FAIL wide_addr0: got %h expected 1234", b_rdata[31:16]); end
        b_we0 = 1'b1; b_wa0 = 6'd63; b_wd0 = 16'h00AB; tick();
        idle(); b_raddr = {6'd63, 6'd63, 6'd63, 6'd63}; #1;
        checks++; if (b_rdata !== {4{16'h00AB}}) begin errors++; $display("FAIL wide_all_ports: got %h expected 00AB x4", b_rdata); end
    endtask

    task automatic test_reset_mid();
        idle();
        rst = 1'b1; a_we0 = 1'b1; a_wa0 = 5'd3; a_wd0 = 32'h99; a_sb = 1'b1; a_sa = 5'd4;
        b_we1 = 1'b1; b_wa1 = 6'd63; b_wd1 = 16'h5A5A; tick();
        rst = 1'b0; idle(); a_raddr = {5'd4, 5'd3}; b_raddr = {6'd63, 6'd0, 6'd63, 6'd0}; #1;
        checks++; if (a_rdata !== 64'd0 || a_rbusy !== 2'b00) begin errors++; $display("FAIL mid_reset_a: got %h/%b expected 0/00", a_rdata, a_rbusy); end
        checks++; if (b_rdata !== 64'd0 || b_rbusy !== 4'b0000) begin errors++; $display("FAIL mid_reset_b: got %h/%b expected 0/0000", b_rdata, b_rbusy); end
    endtask

    function automatic logic [5:0] raddr6();
        return ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
    endfunction

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst   = ($urandom_range(0, 49) == 0);
            a_we0 = $urandom_range(0, 1) == 1; a_wa0 = 5'(raddr6()); a_wd0 = $urandom();
            a_we1 = $urandom_range(0, 1) == 1; a_wa1 = 5'(raddr6()); a_wd1 = $urandom();
            a_sb  = $urandom_range(0, 2) == 0; a_sa  = 5'(raddr6());
            a_raddr = {5'(raddr6()), 5'(raddr6())};
            b_we0 = $urandom_range(0, 1) == 1; b_wa0 = raddr6(); b_wd0 = 16'($urandom());
            b_we1 = $urandom_range(0, 1) == 1; b_wa1 = raddr6(); b_wd1 = 16'($urandom());
            b_sb  = $urandom_range(0, 2) == 0; b_sa  = raddr6();
            b_raddr = {raddr6(), raddr6(), raddr6(), raddr6()};
            #1;
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (a_rdata[p*32 +: 32] !== ea_data(a_raddr[p*5 +: 5]) || a_rbusy[p] !== ea_busy(a_raddr[p*5 +: 5])) begin
                    errors++; $display("FAIL rand_a cyc %0d port %0d: got %h/%b expected %h/%b", c, p, a_rdata[p*32 +: 32], a_rbusy[p], ea_data(a_raddr[p*5 +: 5]), ea_busy(a_raddr[p*5 +: 5]));
                end
            end
            for (int p = 0; p < 4; p++) begin
                checks++;
                if (b_rdata[p*16 +: 16] !== eb_data(b_raddr[p*6 +: 6]) || b_rbusy[p] !== eb_busy(b_raddr[p*6 +: 6])) begin
                    errors++; $display("FAIL rand_b cyc %0d port %0d: got %h/%b expected %h/%b", c, p, b_rdata[p*16 +: 16], b_rbusy[p], eb_data(b_raddr[p*6 +: 6]), eb_busy(b_raddr[p*6 +: 6]));
                end
            end
            tick();
        end
        rst = 1'b0; idle();
    endtask

    initial begin
        rst = 1'b1; idle();
        a_wa0 = 5'd0; a_wa1 = 5'd0; a_sa = 5'd0; a_wd0 = 32'd0; a_wd1 = 32'd0; a_raddr = 10'd0;
        b_wa0 = 6'd0; b_wa1 = 6'd0; b_sa = 6'd0; b_wd0 = 16'd0; b_wd1 = 16'd0; b_raddr = 24'd0;
        for (int k = 0; k < 32; k++) begin ma_mem[k] = 32'd0; ma_busy[k] = 1'b0; end
        for (int k = 0; k < 64; k++) begin mb_mem[k] = 16'd0; mb_busy[k] = 1'b0; end
        test_reset();
        test_bypass();
        test_conflict();
        test_zero_reg();
        test_scoreboard();
        test_wide();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
